bird_control_fsm: RTL

- Sequencing FSM directly upstream of the bird datapath.
- Issues that datapath's 4-bit control code each cycle: clear old sprite, move, redraw, check hit, and fall/escape sequencing.
- Consumes the datapath's draw-done, shot and flying flags.
- Reports round outcome (hit or escaped) to the game-level controller.
- Contains an LFSR for pseudo-random flight direction.

---
 rtl/bird_pkg.sv | 52 +++++
 rtl/bird_if.sv | 29 ++
 rtl/bird_lfsr.sv | 36 +++
 rtl/bird_control_fsm.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/bird_pkg.sv
// ============================================================================
// bird_pkg : control codes, FSM/mode/direction encodings shared with datapath
// Rev 1.0
// ============================================================================
`default_nettype none

package bird_pkg;

  localparam logic [3:0] C_CTRL_HOLD    = 4'd0;
  localparam logic [3:0] C_CTRL_LEFT    = 4'd1;
  localparam logic [3:0] C_CTRL_RIGHT   = 4'd2;
  localparam logic [3:0] C_CTRL_UP      = 4'd3;
  localparam logic [3:0] C_CTRL_DOWN    = 4'd4;
  localparam logic [3:0] C_CTRL_CLEAR   = 4'd5;
  localparam logic [3:0] C_CTRL_DRAW    = 4'd6;
  localparam logic [3:0] C_CTRL_SHOT    = 4'd7;
  localparam logic [3:0] C_CTRL_ESCAPE  = 4'd8;
  localparam logic [3:0] C_CTRL_CHECK   = 4'd9;
  localparam logic [3:0] C_CTRL_PREHOLD = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_CLEAR  = 3'd2,
    ST_MOVE   = 3'd3,
    ST_SETTLE = 3'd4,
    ST_DRAW   = 3'd5,
    ST_CHECK  = 3'd6,
    ST_DONE   = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    MODE_NORMAL   = 2'd0,
    MODE_FALLING  = 2'd1,
    MODE_ESCAPING = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_UP    = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_e;

  // Direction codes LEFT..DOWN are contiguous, starting at 1.
  function automatic logic [3:0] dir_to_ctrl(input dir_e d);
    return {2'b00, d} + C_CTRL_LEFT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bird_if.sv
// ============================================================================
// bird_if : FSM <-> datapath/game handshake bundle (master = control FSM)
// Rev 1.0
// ============================================================================
`default_nettype none

interface bird_if;
  logic       start;
  logic       frame_tick;
  logic       draw_done;
  logic       shot;
  logic       flying;
  logic [3:0] control;
  logic       busy;
  logic       hit;
  logic       escaped;

  modport master (
    input  start, frame_tick, draw_done, shot, flying,
    output control, busy, hit, escaped
  );

  modport slave (
    output start, frame_tick, draw_done, shot, flying,
    input  control, busy, hit, escaped
  );
endinterface

`default_nettype wire

// File: rtl/bird_lfsr.sv
// ============================================================================
// bird_lfsr : 8-bit Fibonacci LFSR (taps 8,6,5,4) with shift enable
// Rev 1.0
// ============================================================================
`default_nettype none

module bird_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       shift_en_i,
  output logic [1:0] tap_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic       w_feedback;

  assign w_feedback = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_comb begin
    lfsr_d = lfsr_q;
    if (shift_en_i) lfsr_d = {lfsr_q[6:0], w_feedback};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign tap_o = lfsr_q[1:0];

endmodule

`default_nettype wire

// File: rtl/bird_control_fsm.sv
// ============================================================================
// bird_control_fsm : sequences clear/move/draw/check for the bird datapath.
// Optional BIRD_SPEEDUP_EN: +1 move step per 128 normal frames (max 4).  Rev 1.0
// ============================================================================
`default_nettype none

module bird_control_fsm
  import bird_pkg::*;
#(
  parameter int         ESCAPE_FRAMES = 600,
  parameter int         DIR_FRAMES    = 16,
  parameter int         SPEED         = 1,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic   clk,
  input  logic   reset_n,
  bird_if.master bus
);

  localparam int FCW_BASE = (ESCAPE_FRAMES > 1) ? $clog2(ESCAPE_FRAMES) : 1;
`ifdef BIRD_SPEEDUP_EN
  localparam int FCW = (FCW_BASE > 10) ? FCW_BASE : 10;
`else
  localparam int FCW = FCW_BASE;
`endif
  localparam int DCW = (DIR_FRAMES > 1) ? $clog2(DIR_FRAMES) : 1;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  dir_e             dir_q, dir_d;
  logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;
  logic [DCW-1:0]   dir_cnt_q, dir_cnt_d;
  logic [1:0]       step_q, step_d;
  logic [3:0]       control_q, control_d;
  logic             busy_q, busy_d;
  logic             hit_q, hit_d;
  logic             escaped_q, escaped_d;

  logic             w_lfsr_shift;
  logic [1:0]       w_lfsr_tap;
  logic [1:0]       w_step_load;

  bird_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk        (clk),
    .reset_n    (reset_n),
    .shift_en_i (w_lfsr_shift),
    .tap_o      (w_lfsr_tap)
  );

  // Extra steps this frame, loaded when leaving CLEAR.
`ifdef BIRD_SPEEDUP_EN
  logic [3:0] w_speed;
  always_comb begin
    w_speed = 4'(SPEED) + {1'b0, frame_cnt_q[9:7]};
    if (w_speed > 4'd4) w_speed = 4'd4;
    w_step_load = (mode_q == MODE_NORMAL) ? 2'(w_speed - 4'd1) : 2'd0;
  end
`else
  assign w_step_load = 2'(SPEED - 1);
`endif

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    dir_d        = dir_q;
    frame_cnt_d  = frame_cnt_q;
    dir_cnt_d    = dir_cnt_q;
    step_d       = step_q;
    busy_d       = busy_q;
    hit_d        = 1'b0;
    escaped_d    = 1'b0;
    w_lfsr_shift = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d     = ST_WAIT;
          busy_d      = 1'b1;
          mode_d      = MODE_NORMAL;
          frame_cnt_d = '0;
          dir_cnt_d   = '0;
          dir_d       = dir_e'(w_lfsr_tap);
        end
      end
      ST_WAIT:  if (bus.frame_tick) state_d = ST_CLEAR;
      ST_CLEAR: begin
        if (bus.draw_done) begin
          state_d = ST_MOVE;
          step_d  = w_step_load;
        end
      end
      ST_MOVE:  state_d = ST_SETTLE;
      ST_SETTLE: begin
        // A finished fall/escape wins over any remaining move steps.
        if (mode_q != MODE_NORMAL && !bus.flying) begin
          state_d   = ST_DONE;
          busy_d    = 1'b0;
          hit_d     = (mode_q == MODE_FALLING);
          escaped_d = (mode_q == MODE_ESCAPING);
        end else if (step_q != 2'd0) begin
          state_d = ST_MOVE;
          step_d  = step_q - 2'd1;
        end else begin
          state_d = ST_DRAW;
        end
      end
      ST_DRAW:  if (bus.draw_done) state_d = ST_CHECK;
      ST_CHECK: begin
        state_d      = ST_WAIT;
        w_lfsr_shift = 1'b1;
        if (mode_q == MODE_NORMAL) begin
          if (bus.shot)                                   mode_d = MODE_FALLING;
          else if (frame_cnt_q == FCW'(ESCAPE_FRAMES - 1)) mode_d = MODE_ESCAPING;
          else                                            frame_cnt_d = frame_cnt_q + 1'b1;
        end
        if (dir_cnt_q == DCW'(DIR_FRAMES - 1)) begin
          dir_cnt_d = '0;
          dir_d     = dir_e'(w_lfsr_tap);
        end else begin
          dir_cnt_d = dir_cnt_q + 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Registered control code follows the state being entered.
  always_comb begin
    control_d = C_CTRL_HOLD;
    case (state_d)
      ST_CLEAR:  control_d = C_CTRL_CLEAR;
      ST_MOVE: begin
        case (mode_q)
          MODE_FALLING:  control_d = C_CTRL_SHOT;
          MODE_ESCAPING: control_d = C_CTRL_ESCAPE;
          default:       control_d = dir_to_ctrl(dir_q);
        endcase
      end
      ST_SETTLE: control_d = C_CTRL_PREHOLD;
      ST_DRAW:   control_d = C_CTRL_DRAW;
      ST_CHECK:  control_d = C_CTRL_CHECK;
      default:   control_d = C_CTRL_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_NORMAL;
      dir_q       <= DIR_LEFT;
      frame_cnt_q <= '0;
      dir_cnt_q   <= '0;
      step_q      <= 2'd0;
      control_q   <= C_CTRL_HOLD;
      busy_q      <= 1'b0;
      hit_q       <= 1'b0;
      escaped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      dir_q       <= dir_d;
      frame_cnt_q <= frame_cnt_d;
      dir_cnt_q   <= dir_cnt_d;
      step_q      <= step_d;
      control_q   <= control_d;
      busy_q      <= busy_d;
      hit_q       <= hit_d;
      escaped_q   <= escaped_d;
    end
  end

  assign bus.control = control_q;
  assign bus.busy    = busy_q;
  assign bus.hit     = hit_q;
  assign bus.escaped = escaped_q;

endmodule

`default_nettype wire
